param_always_ff_bank: RTL and testbench



---
 rtl/param_always_ff_bank.sv | 122 ++++++++++++
 tb/tb_param_always_ff_bank.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/param_always_ff_bank.sv
// param_always_ff_bank: bank of CHANNELS registers updated by hold/load/acc/sub
// commands, with sticky overflow flags, a result stream and a read port.
module param_always_ff_bank #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int CH_W     = $clog2(CHANNELS),
  parameter int SATURATE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [CH_W-1:0]     in_ch,
  input  logic [1:0]          mode,
  input  logic [WIDTH-1:0]    data_in,
  input  logic                clr_ovf,
  input  logic [CH_W-1:0]     rd_ch,
  output logic                out_valid,
  output logic [CH_W-1:0]     out_ch,
  output logic [WIDTH-1:0]    out_data,
  output logic [WIDTH-1:0]    rd_data,
  output logic [CHANNELS-1:0] ovf
);

  localparam logic [1:0] MODE_HOLD = 2'd0;
  localparam logic [1:0] MODE_LOAD = 2'd1;
  localparam logic [1:0] MODE_ACC  = 2'd2;
  localparam logic [1:0] MODE_SUB  = 2'd3;

  localparam int unsigned NCH = CHANNELS;
  localparam bit          SAT = (SATURATE != 0);

  logic [WIDTH-1:0]    bank_q [CHANNELS];
  logic [WIDTH-1:0]    bank_d [CHANNELS];
  logic                out_valid_q, out_valid_d;
  logic [CH_W-1:0]     out_ch_q, out_ch_d;
  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic [WIDTH-1:0]    rd_data_q, rd_data_d;
  logic [CHANNELS-1:0] ovf_q, ovf_d;

  logic                ch_ok;
  logic                accept;
  logic [WIDTH-1:0]    cur;
  logic [WIDTH:0]      sum;
  logic [WIDTH:0]      diff;
  logic [WIDTH-1:0]    res;
  logic                ov;

  assign ch_ok  = ({1'b0, in_ch} < NCH[CH_W:0]);
  assign accept = in_valid && ch_ok;
  assign sum    = {1'b0, cur} + {1'b0, data_in};
  assign diff   = {1'b0, cur} - {1'b0, data_in};

  // Select the addressed channel's current value.
  always_comb begin
    cur = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (in_ch == i[CH_W-1:0]) cur = bank_q[i];
    end
  end

  // Compute the new channel value and whether it over/underflowed.
  always_comb begin
    res = cur;
    ov  = 1'b0;
    unique case (mode)
      MODE_HOLD: res = cur;
      MODE_LOAD: res = data_in;
      MODE_ACC: begin
        ov  = sum[WIDTH];
        res = (ov && SAT) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
      end
      MODE_SUB: begin
        ov  = diff[WIDTH];
        res = (ov && SAT) ? {WIDTH{1'b0}} : diff[WIDTH-1:0];
      end
      default: res = cur;
    endcase
  end

  // Next-state for bank, flags, result stream and read port.
  always_comb begin
    ovf_d       = clr_ovf ? '0 : ovf_q;
    rd_data_d   = '0;
    out_valid_d = accept;
    out_ch_d    = accept ? in_ch : out_ch_q;
    out_data_d  = accept ? res : out_data_q;
    for (int i = 0; i < CHANNELS; i++) begin
      bank_d[i] = bank_q[i];
      if (rd_ch == i[CH_W-1:0]) rd_data_d = bank_q[i];
      if (accept && (in_ch == i[CH_W-1:0])) begin
        bank_d[i] = res;
        if (ov) ovf_d[i] = 1'b1;
      end
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) bank_q[i] <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      rd_data_q   <= '0;
      ovf_q       <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) bank_q[i] <= bank_d[i];
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_data_q  <= out_data_d;
      rd_data_q   <= rd_data_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_data  = out_data_q;
  assign rd_data   = rd_data_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_param_always_ff_bank.sv
// tb_param_always_ff_bank: drives a saturating and a wrapping instance
// with the same commands and compares both to an integer reference model.
module tb_param_always_ff_bank;

  localparam int W    = 8;
  localparam int NC   = 4;
  localparam int CW   = 2;
  localparam int MAXV = (1 << W) - 1;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [CW-1:0] in_ch;
  logic [1:0]    mode;
  logic [W-1:0]  data_in;
  logic          clr_ovf;
  logic [CW-1:0] rd_ch;

  logic          ov_s, ov_w;
  logic [CW-1:0] och_s, och_w;
  logic [W-1:0]  od_s, od_w;
  logic [W-1:0]  rd_s, rd_w;
  logic [NC-1:0] ovf_s, ovf_w;

  int checks = 0;
  int errors = 0;

  // reference state: index 0 = saturating, 1 = wrapping
  int       mb   [2][NC];
  logic [3:0] movf [2];
  int       mov  [2];
  int       moc  [2];
  int       mod  [2];
  int       mrd  [2];

  param_always_ff_bank #(.WIDTH(W), .CHANNELS(NC), .SATURATE(1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ch(in_ch),
    .mode(mode), .data_in(data_in), .clr_ovf(clr_ovf), .rd_ch(rd_ch),
    .out_valid(ov_s), .out_ch(och_s), .out_data(od_s),
    .rd_data(rd_s), .ovf(ovf_s)
  );

  param_always_ff_bank #(.WIDTH(W), .CHANNELS(NC), .SATURATE(0)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ch(in_ch),
    .mode(mode), .data_in(data_in), .clr_ovf(clr_ovf), .rd_ch(rd_ch),
    .out_valid(ov_w), .out_ch(och_w), .out_data(od_w),
    .rd_data(rd_w), .ovf(ovf_w)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < NC; c++) mb[k][c] = 0;
      movf[k] = '0;
      mov[k] = 0; moc[k] = 0; mod[k] = 0; mrd[k] = 0;
    end
  endtask

  task automatic model_edge();
    int b, d, t, n, c;
    bit o;
    if (rst) begin
      model_reset();
      return;
    end
    c = int'(in_ch);
    d = int'(data_in);
    for (int k = 0; k < 2; k++) begin
      mrd[k] = mb[k][rd_ch];
      b = mb[k][c];
      n = b;
      o = 0;
      case (mode)
        2'd1: n = d;
        2'd2: begin
          t = b + d;
          if (t > MAXV) begin
            o = 1;
            n = (k == 0) ? MAXV : t - (MAXV + 1);
          end else n = t;
        end
        2'd3: begin
          t = b - d;
          if (t < 0) begin
            o = 1;
            n = (k == 0) ? 0 : t + (MAXV + 1);
          end else n = t;
        end
        default: n = b;
      endcase
      if (clr_ovf) movf[k] = '0;
      if (in_valid) begin
        mb[k][c] = n;
        if (o) movf[k][c] = 1'b1;
        mov[k] = 1;
        moc[k] = c;
        mod[k] = n;
      end else begin
        mov[k] = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("s_out_valid", 32'(ov_s), 32'(mov[0]));
    chk("s_out_ch", 32'(och_s), 32'(moc[0]));
    chk("s_out_data", 32'(od_s), 32'(mod[0]));
    chk("s_rd_data", 32'(rd_s), 32'(mrd[0]));
    chk("s_ovf", 32'(ovf_s), 32'(movf[0]));
    chk("w_out_valid", 32'(ov_w), 32'(mov[1]));
    chk("w_out_ch", 32'(och_w), 32'(moc[1]));
    chk("w_out_data", 32'(od_w), 32'(mod[1]));
    chk("w_rd_data", 32'(rd_w), 32'(mrd[1]));
    chk("w_ovf", 32'(ovf_w), 32'(movf[1]));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic cmd(input logic v, input int c, input int m,
                     input int d, input logic clr);
    in_valid = v;
    in_ch    = CW'(c);
    mode     = 2'(m);
    data_in  = W'(d);
    clr_ovf  = clr;
    step();
  endtask

  initial begin
    model_reset();
    rst = 1; in_valid = 1; in_ch = 0; mode = 2'd1;
    data_in = 8'h5A; clr_ovf = 0; rd_ch = 0;

    // commands during reset are discarded
    step();
    cmd(1, 1, 1, 8'h77, 0);
    chk("rst_out_valid", 32'(ov_s), 0);
    rst = 0;

    // some activity, then asynchronous reset between edges
    cmd(1, 0, 1, 8'h12, 0);
    cmd(1, 1, 2, 8'hF0, 0);
    cmd(1, 1, 2, 8'h20, 0);
    #2 rst = 1;
    #1;
    model_reset();
    chk("async_out_valid", 32'(ov_s), 0);
    chk("async_out_data", 32'(od_s), 0);
    chk("async_ovf", 32'(ovf_s), 0);
    chk("async_w_ovf", 32'(ovf_w), 0);
    chk("async_rd_data", 32'(rd_s), 0);
    cmd(1, 2, 1, 8'h99, 0);
    rst = 0;

    // read port returns 0 for every channel after release
    for (int i = 0; i < NC; i++) begin
      rd_ch = CW'(i);
      cmd(0, 0, 0, 0, 0);
    end
    rd_ch = CW'(1);
    cmd(0, 0, 0, 0, 0);
    chk("rd_after_rst", 32'(rd_s), 0);

    // load / accumulate / hold
    cmd(1, 0, 1, 8'hAA, 0);
    chk("load_aa", 32'(od_s), 32'hAA);
    cmd(1, 0, 2, 8'h55, 0);
    chk("acc_ff", 32'(od_s), 32'hFF);
    chk("acc_ff_ovf", 32'(ovf_s), 0);
    cmd(1, 0, 0, 8'h00, 0);
    chk("hold_ff", 32'(od_s), 32'hFF);

    // saturate vs wrap
    cmd(1, 0, 2, 8'h02, 0);
    chk("sat_acc", 32'(od_s), 32'hFF);
    chk("wrap_acc", 32'(od_w), 32'h01);
    chk("sat_ovf", 32'(ovf_s), 32'h1);
    cmd(0, 0, 0, 0, 1);
    chk("clr_ovf", 32'(ovf_s), 0);

    // underflow
    cmd(1, 1, 1, 8'h10, 0);
    cmd(1, 1, 3, 8'h20, 0);
    chk("sat_sub", 32'(od_s), 32'h00);
    chk("wrap_sub", 32'(od_w), 32'hF0);
    chk("sub_ovf", 32'(ovf_w), 32'h2);
    cmd(1, 1, 1, 8'h10, 1);
    cmd(1, 1, 3, 8'h10, 0);
    chk("sub_exact", 32'(od_w), 32'h00);
    chk("sub_exact_ovf", 32'(ovf_w), 0);

    // interleave and read port on ch2
    rd_ch = CW'(2);
    cmd(1, 2, 1, 8'h33, 0);
    cmd(1, 3, 1, 8'h44, 0);
    chk("rd_seq1", 32'(rd_s), 32'h33);
    cmd(1, 2, 2, 8'h01, 0);
    chk("il_data", 32'(od_s), 32'h34);
    cmd(0, 0, 0, 0, 0);
    chk("rd_seq3", 32'(rd_s), 32'h34);

    // set wins over clear on the same edge
    cmd(1, 0, 1, 8'hFF, 0);
    cmd(1, 3, 2, 8'hFF, 0);
    cmd(1, 0, 2, 8'h01, 1);
    chk("set_over_clr", 32'(ovf_s), 32'h1);
    cmd(0, 0, 0, 0, 0);
    chk("gap_valid", 32'(ov_s), 0);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      rd_ch = CW'($urandom_range(0, NC - 1));
      cmd(logic'($urandom_range(0, 3) != 0), $urandom_range(0, NC - 1),
          $urandom_range(0, 3), $urandom_range(0, MAXV),
          logic'($urandom_range(0, 9) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
